// File: rtl/reset_seq_pkg.sv
// -----------------------------------------------------------------------------
// reset_seq_pkg
// Shared types and helpers for the staged reset sequencer.
//   seqStateT      : sequencer FSM states (SYNC, HOLD, STAGE, RUN)
//   calcCountWidth : width of the shared hold/gap counter
// -----------------------------------------------------------------------------
package reset_seq_pkg;

    typedef enum logic [1:0] {
        SYNC,
        HOLD,
        STAGE,
        RUN
    } seqStateT;

    // The counter only ever has to reach (longest interval - 1), and it clears
    // at terminal count, so sizing for the largest interval avoids wrap-around.
    function automatic int calcCountWidth(input int porCycles,
                                          input int softCycles,
                                          input int stageGap);
        int longest;
        longest = porCycles;
        if (softCycles > longest) longest = softCycles;
        if (stageGap > longest) longest = stageGap;
        return $clog2(longest + 1);
    endfunction

endpackage

// File: rtl/reset_sync.sv
// -----------------------------------------------------------------------------
// reset_sync
// Asynchronous-assert, synchronous-release reset synchroniser. Also used for
// other clock domains, so it carries no knowledge of the sequencer.
// Ports:
//   i_clk      : destination clock
//   i_rst      : asynchronous reset, active-high
//   o_released : goes high SYNC_STAGES-1 edges after the first edge with
//                i_rst low; drops immediately when i_rst rises
// -----------------------------------------------------------------------------
module reset_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    output logic o_released
);

    logic [SYNC_STAGES-1:0] r_shift;

    // A one ripples in from the bottom once reset is released; any assertion
    // of i_rst clears the whole chain without waiting for a clock.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_shift <= '0;
        end else begin
            r_shift <= {r_shift[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign o_released = r_shift[SYNC_STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// -----------------------------------------------------------------------------
// reset_sequencer
// Holds downstream logic disabled after reset, then releases N_STAGES enables
// in order (stage 0 first) with a programmable gap between releases. A
// soft-reset request drops all enables and re-runs a shorter hold.
// Ports:
//   clk      : system clock
//   rst      : external reset, asynchronous, active-high
//   soft_req : synchronous soft-reset request, sampled every edge
//   stage_en : per-stage enables, thermometer coded from bit 0 upward
//   ready    : all stages enabled
//   busy     : sequencing in progress (not in RUN)
// -----------------------------------------------------------------------------
module reset_sequencer #(
    parameter int N_STAGES    = 3,
    parameter int POR_CYCLES  = 63,
    parameter int SOFT_CYCLES = 16,
    parameter int STAGE_GAP   = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                soft_req,
    output logic [N_STAGES-1:0] stage_en,
    output logic                ready,
    output logic                busy
);

    import reset_seq_pkg::*;

    localparam int CNT_W = calcCountWidth(POR_CYCLES, SOFT_CYCLES, STAGE_GAP);

    localparam logic [CNT_W-1:0] POR_LAST  = CNT_W'(POR_CYCLES - 1);
    localparam logic [CNT_W-1:0] SOFT_LAST = CNT_W'(SOFT_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STAGE_GAP - 1);

    logic                w_released;
    logic [CNT_W-1:0]    w_holdLast;
    logic [CNT_W-1:0]    w_termCount;
    logic [N_STAGES-1:0] w_nextEn;

    seqStateT            r_state;
    logic [CNT_W-1:0]    r_count;
    logic                r_softHold;
    logic [N_STAGES-1:0] r_stageEn;
    logic                r_ready;
    logic                r_busy;

    reset_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_resetSync (
        .i_clk     (clk),
        .i_rst     (rst),
        .o_released(w_released)
    );

    // The hold length depends on what started it: power-on or a soft request.
    assign w_holdLast  = r_softHold ? SOFT_LAST : POR_LAST;
    assign w_termCount = (r_state == HOLD) ? w_holdLast : GAP_LAST;

    // Enables are thermometer coded, so releasing the next stage is a shift
    // with a one fed in; the sequence is done once every bit is set.
    assign w_nextEn = (r_stageEn << 1) | N_STAGES'(1);

    // Sequencer FSM. HOLD and STAGE share one counter that clears whenever it
    // hits its terminal count, so each release lands exactly one interval
    // after the previous event. A soft request outside SYNC overrides
    // everything and restarts the hold from zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= SYNC;
            r_count    <= '0;
            r_softHold <= 1'b0;
            r_stageEn  <= '0;
            r_ready    <= 1'b0;
            r_busy     <= 1'b1;
        end else if (soft_req && (r_state != SYNC)) begin
            r_state    <= HOLD;
            r_count    <= '0;
            r_softHold <= 1'b1;
            r_stageEn  <= '0;
            r_ready    <= 1'b0;
            r_busy     <= 1'b1;
        end else begin
            case (r_state)
                SYNC: begin
                    if (w_released) begin
                        r_state    <= HOLD;
                        r_count    <= '0;
                        r_softHold <= 1'b0;
                    end
                end
                HOLD, STAGE: begin
                    if (r_count == w_termCount) begin
                        r_count   <= '0;
                        r_stageEn <= w_nextEn;
                        if (&w_nextEn) begin
                            r_state <= RUN;
                            r_ready <= 1'b1;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state <= STAGE;
                        end
                    end else begin
                        r_count <= r_count + CNT_W'(1);
                    end
                end
                RUN: begin
                    r_state <= RUN;
                end
                default: begin
                    r_state <= SYNC;
                end
            endcase
        end
    end

    assign stage_en = r_stageEn;
    assign ready    = r_ready;
    assign busy     = r_busy;

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
- Parametrised successor to the single-output power-on enable generator.
- Holds all downstream logic disabled after configuration or external reset, then releases N_STAGES enable outputs in fixed order (stage 0 first) with programmable gaps between them.
- Adds an asynchronous external reset with synchronised release, plus a synchronous soft-reset request that re-runs the sequence.
- Sits at the top level and drives the enables of the clocking, acquisition and output sections.

Parameters:
- N_STAGES, 3, number of staged enable outputs (>=1).
- POR_CYCLES, 63, hold length in clk cycles after the release of rst (>=1).
- SOFT_CYCLES, 16, hold length in clk cycles after a soft reset request (>=1).
- STAGE_GAP, 8, clk cycles between consecutive stage releases (>=1).
- SYNC_STAGES, 2, depth of the reset-release synchroniser (>=2).

Ports:
- clk  in  1  system clock, 40 MHz.
- rst  in  1  external reset, asynchronous, active-high.
- soft_req  in  1  synchronous soft-reset request, sampled every edge.
- stage_en  out  N_STAGES  per-stage global enable, active-high.
- ready  out  1  high when all stages are enabled.
- busy  out  1  high while sequencing (any state other than RUN).

Behaviour:
- Reset is asynchronous and active-high.
  - While rst=1: stage_en=0, ready=0, busy=1, synchroniser cleared, state=SYNC, counter=0.
  - These values take effect immediately, without waiting for a clk edge.
  - Power-up register values are identical to the reset values.
- Release synchroniser:
  - SYNC_STAGES flops, asynchronously cleared by rst, shifting in 1.
  - E0 is the first clk edge at which rst is low.
  - The synchroniser output is 1 after edge E0+SYNC_STAGES-1.
- FSM states: SYNC, HOLD, STAGE, RUN.
- SYNC:
  - Wait for the synchroniser output.
  - Go to HOLD at edge E0+SYNC_STAGES, with counter=0 and hold length=POR_CYCLES.
- HOLD:
  - Counter increments each edge.
  - When counter reaches length-1, the next edge sets stage_en[0]=1, clears the counter, and goes to STAGE.
  - If N_STAGES=1, that edge goes directly to RUN.
- STAGE:
  - Stage k rises exactly STAGE_GAP edges after stage k-1.
  - Stages already released stay high.
  - At the edge the last stage rises: ready=1, busy=0, state=RUN.
- Timing with defaults (N=3): stage_en[0] rises at E0+65, stage_en[1] at E0+73, stage_en[2] and ready at E0+81.
- RUN: outputs remain stable until rst or soft_req.
- soft_req=1 sampled at edge S in HOLD, STAGE or RUN:
  - At edge S: stage_en=0, ready=0, busy=1, counter=0, state=HOLD with length=SOFT_CYCLES.
  - Stage 0 rises at S+SOFT_CYCLES; stage k at S+SOFT_CYCLES+k*STAGE_GAP.
  - A request in HOLD or STAGE restarts the sequence. Stages already released drop at S.
- soft_req in SYNC is ignored.
- soft_req held high restarts the hold every cycle. The sequence proceeds only after soft_req returns low.
- rst asserted mid-sequence or in RUN: immediate return to the reset values; the full POR sequence follows.
- A glitch on rst shorter than one clk period still clears everything.
- Counter width: $clog2(max(POR_CYCLES, SOFT_CYCLES, STAGE_GAP)+1). There is no wrap-around, because the counter always clears at terminal count.
- stage_en is monotonic within a sequence. No stage is ever enabled while a lower-indexed stage is disabled.

Decomposition:
- Package reset_seq_pkg: FSM state enum (SYNC, HOLD, STAGE, RUN) and a function computing the counter width.
- Sub-module reset_sync: SYNC_STAGES-deep asynchronous-assert, synchronous-release synchroniser. It is reused elsewhere for other clock domains.

Test Plan:
- Power-up with defaults, rst pulsed 3 cycles then low (E0) -> stage_en 000 until E0+65; 001 at E0+65, 011 at E0+73, 111 plus ready=1, busy=0 at E0+81.
- In RUN, soft_req 1-cycle pulse at edge S -> stage_en=000, ready=0 at S; 001 at S+16, 011 at S+24, 111 at S+32.
- soft_req pulse at E0+70 (during STAGE, stage_en=001) -> stage_en drops to 000 at E0+70; 001 at E0+86, 111 at E0+102.
- rst asserted asynchronously mid-clock at E0+75 -> stage_en=000 and ready=0 before the next edge; after release at E1, stage_en[0] rises at E1+65.
- soft_req held high for 10 cycles starting at edge S in RUN, last high at S+9 -> stage_en[0] rises at S+9+16 = S+25.
- N_STAGES=1, POR_CYCLES=4, SYNC_STAGES=2 -> stage_en[0] and ready rise together at E0+6; soft_req during SYNC has no effect.
